// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES loopback self-test:
//   - AES_BLOCK_W  : AES block width in bits
//   - chk_state_t  : sequencing states of the loopback checker
//   - AES128_*     : FIPS-197 Appendix C.1 AES-128 known-answer vector
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CIPHER,
    ST_WAIT_PLAIN,
    ST_PASS,
    ST_FAIL
  } chk_state_t;

  localparam logic [AES_BLOCK_W-1:0] AES128_PLAIN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [AES_BLOCK_W-1:0] AES128_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [AES_BLOCK_W-1:0] AES128_CIPHER = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/led_blinker.sv
// ---------------------------------------------------------------------------
// led_blinker
// Square-wave generator for the fail indication. While en=0 the blinker is
// held in its start phase; the first enabled cycle shows out=1, and out
// toggles every HALF_PERIOD enabled cycles after that.
//
// Parameters:
//   HALF_PERIOD  clk cycles per half-period (>= 2)
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-low reset
//   en    in   1 = blink, 0 = hold in start phase (out forced low)
//   out   out  blink output
// ---------------------------------------------------------------------------
module led_blinker #(
  parameter int HALF_PERIOD = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic out
);

  localparam int                CNT_W    = $clog2(HALF_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  // The phase flop already holds 1 while disabled, so gating with en makes
  // the very first enabled cycle light the LED without a cycle of lag.
  assign out = en & phase;

endmodule

// File: rtl/aes_loopback_checker.sv
// ---------------------------------------------------------------------------
// aes_loopback_checker
// Self-test sequencer placed after the AES encrypt/decrypt loopback. A start
// pulse captures the reference plaintext/ciphertext; the checker then waits
// for the ciphertext strobe, then for the recovered-plaintext strobe, compares
// each against its captured reference and reports the result on three LEDs.
// A per-stage watchdog turns a missing strobe into a failure.
//
// Parameters:
//   BLOCK_W         block width in bits
//   TIMEOUT_CYCLES  max cycles from stage entry to the expected strobe
//   BLINK_HALF      half-period of the fail blink in clk cycles (>= 2)
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous, active-low reset
//   start         in   one-cycle pulse, begins a run (ignored while busy)
//   plain_ref     in   plaintext fed to the encryptor, sampled on start
//   cipher_ref    in   expected ciphertext, sampled on start
//   cipher_in     in   ciphertext from the encryption path
//   cipher_valid  in   one-cycle strobe qualifying cipher_in
//   plain_in      in   recovered plaintext from the decryption path
//   plain_valid   in   one-cycle strobe qualifying plain_in
//   led1          out  ciphertext matched
//   led2          out  recovered plaintext matched
//   led3          out  steady = overall pass, blinking = fail/timeout
//   busy          out  run in progress
//   done          out  one-cycle pulse on entry to PASS or FAIL
//   timeout       out  sticky: last run failed by watchdog
// ---------------------------------------------------------------------------
module aes_loopback_checker
  import aes_pkg::*;
#(
  parameter int BLOCK_W        = AES_BLOCK_W,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int BLINK_HALF     = 12500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] plain_ref,
  input  logic [BLOCK_W-1:0] cipher_ref,
  input  logic [BLOCK_W-1:0] cipher_in,
  input  logic               cipher_valid,
  input  logic [BLOCK_W-1:0] plain_in,
  input  logic               plain_valid,
  output logic               led1,
  output logic               led2,
  output logic               led3,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int               WDOG_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  chk_state_t         state;
  logic [BLOCK_W-1:0] plain_ref_q;
  logic [BLOCK_W-1:0] cipher_ref_q;
  logic [WDOG_W-1:0]  wdog;
  logic [WDOG_W-1:0]  wdog_next;
  logic               cipher_ok;
  logic               led_pass;
  logic               blink_out;
  logic               cipher_match;
  logic               plain_match;
  logic               wdog_expired;

  assign cipher_match = (cipher_in == cipher_ref_q);
  assign plain_match  = (plain_in  == plain_ref_q);
  assign wdog_expired = (wdog == WDOG_LAST);
  // Saturating increment: the counter can never wrap back to a "fresh" value.
  assign wdog_next    = (wdog == '1) ? wdog : wdog + WDOG_W'(1);

  led_blinker #(
    .HALF_PERIOD (BLINK_HALF)
  ) u_blinker (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_FAIL),
    .out (blink_out)
  );

  // led_pass and the blinker are never active together, so the OR simply
  // selects whichever indication belongs to the current terminal state.
  assign led3 = led_pass | blink_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      // NOTE: the captured references are reset like any other register;
      // they are two wide flops, not a memory array, and a clean reset state
      // keeps a post-reset compare deterministic.
      plain_ref_q  <= '0;
      cipher_ref_q <= '0;
      wdog         <= '0;
      cipher_ok    <= 1'b0;
      led1         <= 1'b0;
      led2         <= 1'b0;
      led_pass     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (start) begin
            plain_ref_q  <= plain_ref;
            cipher_ref_q <= cipher_ref;
            wdog         <= '0;
            cipher_ok    <= 1'b0;
            led1         <= 1'b0;
            led2         <= 1'b0;
            led_pass     <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_WAIT_CIPHER;
          end
        end

        ST_WAIT_CIPHER: begin
          if (cipher_valid && plain_valid) begin
            // Both halves of the loopback finished together: decide now.
            led1     <= cipher_match;
            led2     <= plain_match;
            led_pass <= cipher_match && plain_match;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= (cipher_match && plain_match) ? ST_PASS : ST_FAIL;
          end else if (cipher_valid) begin
            cipher_ok <= cipher_match;
            led1      <= cipher_match;
            wdog      <= '0;
            state     <= ST_WAIT_PLAIN;
          end else if (plain_valid) begin
            // Decryption cannot legitimately finish before encryption.
            led1  <= 1'b0;
            led2  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FAIL;
          end else if (wdog_expired) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_FAIL;
          end else begin
            wdog <= wdog_next;
          end
        end

        ST_WAIT_PLAIN: begin
          // Late or repeated cipher_valid strobes are deliberately ignored.
          if (plain_valid) begin
            led2     <= plain_match;
            led_pass <= cipher_ok && plain_match;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= (cipher_ok && plain_match) ? ST_PASS : ST_FAIL;
          end else if (wdog_expired) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_FAIL;
          end else begin
            wdog <= wdog_next;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_loopback_checker.sv
// ---------------------------------------------------------------------------
// tb_aes_loopback_checker
// Scoreboard bench: each run's expected outcome is computed from the strobe
// offsets and data matches, queued on start, and checked by an independent
// monitor whenever the DUT pulses done (including the LED3 pattern after it).
// ---------------------------------------------------------------------------
module tb_aes_loopback_checker;
  import aes_pkg::*;

  localparam int T    = 64;   // watchdog limit used in simulation
  localparam int HALF = 4;    // blink half-period used in simulation
  localparam int NEVER = -1;

  typedef struct {
    int done_edge;
    bit l1;
    bit l2;
    bit to;
    bit pass;
    int dec;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] plain_ref = '0;
  logic [127:0] cipher_ref = '0;
  logic [127:0] cipher_in = '0;
  logic         cipher_valid = 1'b0;
  logic [127:0] plain_in = '0;
  logic         plain_valid = 1'b0;
  logic         led1, led2, led3, busy, done, timeout;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  aes_loopback_checker #(
    .BLOCK_W        (128),
    .TIMEOUT_CYCLES (T),
    .BLINK_HALF     (HALF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .plain_ref    (plain_ref),
    .cipher_ref   (cipher_ref),
    .cipher_in    (cipher_in),
    .cipher_valid (cipher_valid),
    .plain_in     (plain_in),
    .plain_valid  (plain_valid),
    .led1         (led1),
    .led2         (led2),
    .led3         (led3),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: offsets are counted in cycles from the start strobe.
  // A stage accepts its strobe up to T cycles after that stage began.
  function automatic exp_t model(input bit cm, input bit pm, input int c, input int p);
    exp_t e;
    int   fc, fp;
    fc = (c < 0) ? 1_000_000 : c;
    fp = (p < 0) ? 1_000_000 : p;
    e = '{done_edge: 0, l1: 0, l2: 0, to: 0, pass: 0, dec: 0};
    if (fc > T && fp > T) begin
      e.dec = T; e.to = 1;
    end else if (fc == fp) begin
      e.dec = fc; e.l1 = cm; e.l2 = pm; e.pass = cm && pm;
    end else if (fp < fc) begin
      e.dec = fp;
    end else begin
      e.l1 = cm;
      if (fp <= fc + T) begin
        e.dec = fp; e.l2 = pm; e.pass = cm && pm;
      end else begin
        e.dec = fc + T; e.to = 1;
      end
    end
    return e;
  endfunction

  // Drives one run. dup_start re-pulses start (with junk refs) mid-run;
  // recipher injects a second, corrupt cipher_valid while awaiting plaintext.
  task automatic do_run(input logic [127:0] pref, input logic [127:0] cref,
                        input logic [127:0] cin, input logic [127:0] pin,
                        input int c_off, input int p_off,
                        input int dup_start, input bit recipher);
    exp_t e;
    e = model(cin == cref, pin == pref, c_off, p_off);
    for (int off = 0; off <= e.dec; off++) begin
      @(negedge clk);
      if (off == 0) begin
        e.done_edge = cyc + 1 + e.dec;
        sb.push_back(e);
      end
      start        = (off == 0) || (off == dup_start);
      plain_ref    = (off == 0) ? pref : rand128();
      cipher_ref   = (off == 0) ? cref : rand128();
      cipher_valid = (off == c_off) || (recipher && c_off >= 0 && off == c_off + 2);
      cipher_in    = (off == c_off) ? cin : rand128();
      plain_valid  = (off == p_off);
      plain_in     = (off == p_off) ? pin : rand128();
    end
    @(negedge clk);
    start = 0; cipher_valid = 0; plain_valid = 0;
    repeat (12) @(negedge clk);
  endtask

  // Monitor: pops one expectation per done pulse and checks the result,
  // then follows LED3/done/timeout for two blink periods.
  initial begin
    exp_t e;
    int   bad;
    bit   exp3;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: actual=done with empty queue required=no done (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_edge);
          check("led1", int'(led1), int'(e.l1));
          check("led2", int'(led2), int'(e.l2));
          check("timeout", int'(timeout), int'(e.to));
          check("busy_after_done", int'(busy), 0);
          check("led3_entry", int'(led3), 1);
          bad = 0;
          for (int k = 1; k <= 2 * HALF + 1; k++) begin
            @(negedge clk);
            if (busy || !rst) break;
            exp3 = e.pass ? 1'b1 : (((k / HALF) % 2) == 0);
            if (led3 !== exp3 || done !== 1'b0 || timeout !== e.to) bad++;
          end
          check("led3_pattern_after_done", bad, 0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: actual=still running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [127:0] bad_cipher;
    int c, p;

    // Reset state, both during and right after reset.
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({led1, led2, led3, busy, done, timeout}), 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outputs", int'({led1, led2, led3, busy, done, timeout}), 0);

    // FIPS-197 vector, cipher at +40, plaintext at +90.
    do_run(AES128_PLAIN, AES128_CIPHER, AES128_CIPHER, AES128_PLAIN, 40, 90, NEVER, 0);
    // Ciphertext LSB flipped, plaintext correct.
    bad_cipher = AES128_CIPHER ^ 128'h1;
    do_run(AES128_PLAIN, AES128_CIPHER, bad_cipher, AES128_PLAIN, 10, 20, NEVER, 0);
    // No strobes at all: watchdog.
    do_run(AES128_PLAIN, AES128_CIPHER, AES128_CIPHER, AES128_PLAIN, NEVER, NEVER, NEVER, 0);
    // Simultaneous strobes, both correct.
    do_run(AES128_PLAIN, AES128_CIPHER, AES128_CIPHER, AES128_PLAIN, 15, 15, NEVER, 0);
    // Plaintext before ciphertext: protocol error.
    do_run(AES128_PLAIN, AES128_CIPHER, AES128_CIPHER, AES128_PLAIN, 9, 5, NEVER, 0);
    // Strobes at the last accepted watchdog cycle of each stage.
    do_run(AES128_PLAIN, AES128_CIPHER, AES128_CIPHER, AES128_PLAIN, T, 2 * T, NEVER, 0);
    // Ciphertext one cycle too late.
    do_run(AES128_PLAIN, AES128_CIPHER, AES128_CIPHER, AES128_PLAIN, T + 1, T + 5, NEVER, 0);
    // Plaintext one cycle too late after a good ciphertext.
    do_run(AES128_PLAIN, AES128_CIPHER, AES128_CIPHER, AES128_PLAIN, 3, 3 + T + 1, NEVER, 0);
    // start during WAIT_PLAIN with other refs, plus a stray cipher_valid.
    do_run(AES128_PLAIN, AES128_CIPHER, AES128_CIPHER, AES128_PLAIN, 10, 50, 30, 1);

    // Reset in WAIT_PLAIN: outputs drop immediately, no done pulse.
    @(negedge clk);
    start = 1; plain_ref = AES128_PLAIN; cipher_ref = AES128_CIPHER;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    cipher_valid = 1; cipher_in = AES128_CIPHER;
    @(negedge clk);
    cipher_valid = 0;
    repeat (3) @(negedge clk);
    check("busy_mid_run", int'(busy), 1);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", int'({led1, led2, led3, busy, done, timeout}), 0);
    repeat (2) @(negedge clk);
    check("held_reset_outputs", int'({led1, led2, led3, busy, done, timeout}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    do_run(AES128_PLAIN, AES128_CIPHER, AES128_CIPHER, AES128_PLAIN, 7, 19, NEVER, 0);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      logic [127:0] pr, cr, ci, pi;
      pr = rand128();
      cr = rand128();
      ci = ($urandom_range(0, 2) == 0) ? cr ^ (128'h1 << $urandom_range(0, 127)) : cr;
      pi = ($urandom_range(0, 2) == 0) ? pr ^ (128'h1 << $urandom_range(0, 127)) : pr;
      c  = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, T + 3));
      if ($urandom_range(0, 7) == 0)      p = NEVER;
      else if (c < 0)                     p = int'($urandom_range(1, T + 3));
      else if ($urandom_range(0, 5) == 0) p = c;
      else                                p = int'($urandom_range(1, c + T + 3));
      do_run(pr, cr, ci, pi, c, p, ($urandom_range(0, 3) == 0) ? 2 : NEVER, $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_loopback_checker.md
Name: aes_loopback_checker

Overview:
- Sits directly downstream of the encrypt/decrypt loopback.
- Consumes the ciphertext from the encryption path and the recovered plaintext from the decryption path.
- Compares both against reference values and drives the three board LEDs with a pass/fail indication.
- Replaces the bare LED wiring with a sequenced self-test result: per-run capture, per-stage compare, timeout watchdog, fail blink.

Parameters:
- BLOCK_W, 128, AES block width in bits.
- TIMEOUT_CYCLES, 65536, max clk cycles from start to each expected valid pulse.
- BLINK_HALF, 12500000, clk cycles per half-period of the fail blink; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a check run.
- plain_ref  in  BLOCK_W  plaintext sent to the encryptor; sampled on start.
- cipher_ref  in  BLOCK_W  expected ciphertext; sampled on start.
- cipher_in  in  BLOCK_W  ciphertext from the encryption path; valid when cipher_valid=1.
- cipher_valid  in  1  one-cycle strobe: ciphertext complete.
- plain_in  in  BLOCK_W  recovered plaintext from the decryption path; valid when plain_valid=1.
- plain_valid  in  1  one-cycle strobe: decryption complete.
- led1  out  1  ciphertext matched.
- led2  out  1  recovered plaintext matched.
- led3  out  1  steady on = overall pass; blinking = fail/timeout.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on entry to PASS or FAIL.
- timeout  out  1  sticky; last run failed by watchdog.

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - All outputs 0; captured refs 0; counters 0.
  - Reset mid-run aborts immediately with no done pulse.
- States: IDLE, WAIT_CIPHER, WAIT_PLAIN, PASS, FAIL. All outputs are registered.
- IDLE:
  - start=1 -> capture plain_ref/cipher_ref; clear led1/led2/timeout; wdog=0; busy=1 next cycle; go WAIT_CIPHER.
- WAIT_CIPHER:
  - wdog increments each cycle.
  - cipher_valid -> cipher_ok = (cipher_in == captured cipher_ref); led1 = cipher_ok; wdog=0; go WAIT_PLAIN.
  - cipher_valid and plain_valid in the same cycle -> both compares done that cycle; led1/led2 set; go PASS if both match, else FAIL.
  - plain_valid alone -> protocol error; go FAIL, led1=led2=0.
  - wdog reaching TIMEOUT_CYCLES-1 without a valid -> timeout=1; go FAIL.
- WAIT_PLAIN:
  - wdog increments each cycle.
  - plain_valid -> plain_ok = (plain_in == captured plain_ref); led2 = plain_ok; go PASS if cipher_ok && plain_ok, else FAIL.
  - Further cipher_valid is ignored.
  - Watchdog expiry -> timeout=1; go FAIL.
- start while busy is ignored; refs are not recaptured.
- Entry to PASS/FAIL:
  - done=1 for exactly one cycle; busy=0.
  - Latency: done asserts the cycle after the deciding valid strobe.
- PASS: led3=1 steady.
- FAIL:
  - led3 toggles every BLINK_HALF cycles; blink counter starts at 0 and led3 starts at 1 on entry.
- PASS/FAIL and start=1 -> same as IDLE start; led3 cleared.
- Comparisons are full BLOCK_W equality, no masking. The watchdog counter is ceil(log2(TIMEOUT_CYCLES)) bits and saturates, never wraps.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128.
  - State enum chk_state_t.
  - FIPS-197 AES-128 vector constants: plaintext, key, ciphertext.
- One sub-module: led_blinker (clk, rst, en, half-period parameter -> out). It is reset when en=0, and its output is 1 on the first enabled cycle.

Test Plan:
- Pass run: plain_ref=00112233445566778899aabbccddeeff, cipher_ref=69c4e0d86a7b0430d8cdb78070b4c55a; feed matching cipher_valid at +40 and plain_valid at +90 -> led1=led2=led3=1, done one pulse at cycle +91, timeout=0.
- Bad cipher: cipher_in=69c4...c55b (LSB flipped), plaintext correct -> led1=0, led2=1, led3 blinks with period 2*BLINK_HALF (BLINK_HALF=4 in sim).
- Timeout: TIMEOUT_CYCLES=16, start, no valids -> FAIL 16 cycles after WAIT_CIPHER entry, timeout=1, led1=led2=0.
- Simultaneous cipher_valid and plain_valid, both correct -> PASS in one step. plain_valid before cipher_valid -> FAIL.
- Reset mid-run: rst low during WAIT_PLAIN -> all outputs 0 asynchronously, no done. Restart passes.
- start pulsed during WAIT_PLAIN with different plain_ref -> ignored; the original refs are used and the run passes.
